skid_stall_pipe: RTL

N-stage linear pipeline with per-stage stall requests and consumer-side backpressure, where backpressure travels upstream one stage per cycle. Each stage has a one-entry skid buffer, so no combinational ready chain runs across the pipe. It pairs with the combinational-stall pipeline: it is the registered-backpressure variant, placed where a pipeline feeds a consumer that can refuse data (`out_accept`).

---
 rtl/skid_stall_pipe_pkg.sv | 16 +
 rtl/skid_stall_pipe_skid_stage.sv | 58 +++++
 rtl/skid_stall_pipe.sv | 72 +++++++
 3 files changed

// File: rtl/skid_stall_pipe_pkg.sv
// Shared types and sizing helpers for the registered-backpressure stall pipeline.
package skid_stall_pipe_pkg;

    localparam int DEFAULT_W = 32;

    typedef struct packed {
        logic                 vld;
        logic [DEFAULT_W-1:0] data;
    } stage_t;

    // Occupancy ranges over 0..2N inclusive.
    function automatic int OCC_W(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/skid_stall_pipe_skid_stage.sv
// One pipeline stage: a main entry plus a one-entry skid buffer, ready is a flop.
// Valid/ready: a beat moves when valid and ready are both high at a clock edge.
module skid_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_vld,
    input  logic [W-1:0] up_data,
    output logic         up_rdy,
    input  logic         stall,
    input  logic         dn_rdy,
    output logic         dn_vld,
    output logic [W-1:0] dn_data
);

    logic         main_vld;
    logic         skid_vld;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         xi;
    logic         xo;

    assign up_rdy  = ~skid_vld;
    assign dn_vld  = main_vld & ~stall;
    assign dn_data = main_data;
    assign xi      = up_vld & ~skid_vld;
    assign xo      = dn_vld & dn_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            if (xo) skid_vld <= 1'b0;
        end else if (xi && main_vld && !xo) begin
            skid_vld <= 1'b1;
        end else if (xi) begin
            main_vld <= 1'b1;
        end else if (xo) begin
            main_vld <= 1'b0;
        end
    end

    // Data registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (skid_vld) begin
            if (xo) main_data <= skid_data;
        end else if (xi && main_vld && !xo) begin
            skid_data <= up_data;
        end else if (xi) begin
            main_data <= up_data;
        end
    end

    a_skid_implies_main : assert property (@(posedge clk) disable iff (rst) skid_vld |-> main_vld);

endmodule

// File: rtl/skid_stall_pipe.sv
// N-stage skid-buffered pipeline with per-stage stalls and registered backpressure.
// Optional occupancy output occ_r is enabled by defining SKID_STALL_PIPE_OCC_EN.
module skid_stall_pipe
    import skid_stall_pipe_pkg::*;
#(
    parameter int N = 4,
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in,
    input  logic         in_vld,
    output logic         in_accept,
    output logic [W-1:0] out,
    output logic         out_vld,
    input  logic         out_accept,
    input  logic [N-1:0] stall_req
`ifdef SKID_STALL_PIPE_OCC_EN
    ,
    output logic [OCC_W(N)-1:0] occ_r
`endif
);

    // Link k sits between stage k-1 and stage k; link 0 is the input, link N the output.
    logic         link_vld  [N+1];
    logic         link_rdy  [N+1];
    logic [W-1:0] link_data [N+1];

    assign link_vld[0]  = in_vld;
    assign link_data[0] = in;
    assign link_rdy[N]  = out_accept;

    for (genvar i = 0; i < N; i++) begin : g_stage
        skid_stage #(.W(W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .up_vld  (link_vld[i]),
            .up_data (link_data[i]),
            .up_rdy  (link_rdy[i]),
            .stall   (stall_req[i]),
            .dn_rdy  (link_rdy[i+1]),
            .dn_vld  (link_vld[i+1]),
            .dn_data (link_data[i+1])
        );
    end

    assign in_accept = link_rdy[0];
    assign out       = link_data[N];
    assign out_vld   = link_vld[N];

`ifdef SKID_STALL_PIPE_OCC_EN
    localparam int OW = OCC_W(N);
    localparam logic [OW-1:0] OCC_ONE = OW'(1);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_vld & in_accept;
    assign out_xfer = out_vld & out_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ_r <= occ_r + OCC_ONE;
        end else if (out_xfer && !in_xfer) begin
            occ_r <= occ_r - OCC_ONE;
        end
    end
`endif

endmodule
